// File: rtl/softmax_layer_core.sv
// Softmax + one-hot subtraction for N rows of CHAR_NUM Q8.8 logits, producing
// Q2.14 cross-entropy gradients. One exp per cycle, serial divide, one output per cycle.
module softmax_layer_core #(
  parameter int N        = 10,
  parameter int CHAR_NUM = 200,
  parameter int CHAR_LEN = 8,
  parameter int N_LEN    = 16,
  parameter int N_FRAC   = 8,
  parameter int N_LEN_W  = 16,
  parameter int W_FRAC   = 14
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             run,
  input  logic                             load_d_num,
  input  logic [N*CHAR_NUM*N_LEN-1:0]      d,
  input  logic [N*CHAR_LEN-1:0]            d_num,
  input  logic [N*N_LEN-1:0]               d_max,
  output logic                             valid,
  output logic [N*CHAR_NUM*N_LEN_W-1:0]    q
);

  localparam int ROW_W = (N > 1) ? $clog2(N) : 1;
  localparam int COL_W = (CHAR_NUM > 1) ? $clog2(CHAR_NUM) : 1;
  localparam int SUM_W = 16 + $clog2(CHAR_NUM);
  localparam int E_W   = 15;
  localparam int R_W   = 29;
  localparam int X_W   = N_LEN + 1;
  localparam int Y_W   = N_LEN + 11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {PH_EXP, PH_DIV, PH_NORM, PH_FIN} phase_t;

  state_t                      state;
  phase_t                      phase;
  logic [ROW_W-1:0]            row;
  logic [COL_W-1:0]            col;
  logic [4:0]                  div_cnt;
  logic [SUM_W-1:0]            sum;
  logic [SUM_W-1:0]            rem;
  logic [R_W-1:0]              quot;
  logic [N*CHAR_LEN-1:0]       lbl;
  logic [E_W-1:0]              e_buf [CHAR_NUM];
  logic signed [N_LEN_W-1:0]   q_arr [N][CHAR_NUM];

  logic signed [N_LEN-1:0]     d_elem    [N][CHAR_NUM];
  logic signed [N_LEN-1:0]     dmax_elem [N];
  logic [CHAR_LEN-1:0]         lbl_elem  [N];

  logic [E_W-1:0]              e_cur;
  logic [SUM_W-1:0]            sum_nxt;
  logic [SUM_W-1:0]            rem_cur;
  logic [R_W-1:0]              quot_cur;
  logic [SUM_W:0]              rem_sh;
  logic [SUM_W-1:0]            rem_nxt;
  logic [R_W-1:0]              quot_nxt;
  logic [R_W-1:0]              r_eff;
  logic                        hit;

  for (genvar i = 0; i < N; i++) begin : g_row
    assign dmax_elem[i] = d_max[i*N_LEN +: N_LEN];
    assign lbl_elem[i]  = lbl[i*CHAR_LEN +: CHAR_LEN];
    for (genvar j = 0; j < CHAR_NUM; j++) begin : g_col
      assign d_elem[i][j] = d[(i*CHAR_NUM+j)*N_LEN +: N_LEN];
      assign q[(i*CHAR_NUM+j)*N_LEN_W +: N_LEN_W] = q_arr[i][j];
    end
  end

  // 2^x approximation: integer part becomes a right shift, fraction a linear mantissa
  function automatic logic [E_W-1:0] exp_q14(input logic signed [N_LEN-1:0] dv,
                                             input logic signed [N_LEN-1:0] mv);
    logic signed [X_W-1:0] x;
    logic signed [Y_W-1:0] y;
    logic signed [Y_W-1:0] neg_k;
    logic [E_W-1:0]        mant;
    logic [E_W-1:0]        res;
    x = X_W'(dv) - X_W'(mv);
    if (x > 0) x = '0;
    y     = (Y_W'(x) * Y_W'(369)) >>> N_FRAC;
    neg_k = -(y >>> N_FRAC);
    mant  = {1'b1, y[N_FRAC-1:0], 6'b0};
    if (neg_k >= Y_W'(15)) res = '0;
    else                   res = mant >> neg_k[3:0];
    return res;
  endfunction

  function automatic logic signed [N_LEN_W-1:0] grad_q14(input logic [E_W-1:0] ev,
                                                         input logic [R_W-1:0] rv,
                                                         input logic           lbl_hit);
    logic [E_W+R_W-1:0] p;
    logic [E_W+R_W:0]   v;
    p = (E_W+R_W)'(ev) * (E_W+R_W)'(rv);
    v = {1'b0, p >> W_FRAC} - (lbl_hit ? (E_W+R_W+1)'(1 << W_FRAC) : '0);
    return N_LEN_W'(v);
  endfunction

  always_comb begin
    e_cur    = exp_q14(d_elem[row][col], dmax_elem[row]);
    sum_nxt  = ((col == '0) ? '0 : sum) + SUM_W'(e_cur);
    // First divide step folds in the leading dividend bit (2^28)
    rem_cur  = (div_cnt == '0) ? ((sum == SUM_W'(1)) ? '0 : SUM_W'(1)) : rem;
    quot_cur = (div_cnt == '0) ? R_W'(sum == SUM_W'(1)) : quot;
    rem_sh   = {rem_cur, 1'b0};
    rem_nxt  = SUM_W'(rem_sh);
    quot_nxt = {quot_cur[R_W-2:0], 1'b0};
    if (rem_sh >= {1'b0, sum}) begin
      rem_nxt  = SUM_W'(rem_sh - {1'b0, sum});
      quot_nxt = {quot_cur[R_W-2:0], 1'b1};
    end
    r_eff = (sum == '0) ? '0 : quot;
    hit   = (32'(col) == 32'(lbl_elem[row]));
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state   <= IDLE;
      phase   <= PH_EXP;
      row     <= '0;
      col     <= '0;
      div_cnt <= '0;
      sum     <= '0;
      rem     <= '0;
      quot    <= '0;
      lbl     <= '0;
      valid   <= 1'b0;
      for (int j = 0; j < CHAR_NUM; j++) e_buf[j] <= '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < CHAR_NUM; j++) q_arr[i][j] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_d_num) lbl <= d_num;
          if (run) begin
            state <= BUSY;
            phase <= PH_EXP;
            row   <= '0;
            col   <= '0;
          end
        end
        BUSY: begin
          case (phase)
            PH_EXP: begin
              e_buf[col] <= e_cur;
              sum        <= sum_nxt;
              div_cnt    <= '0;
              if (col == COL_W'(CHAR_NUM-1)) begin
                col   <= '0;
                phase <= PH_DIV;
              end else begin
                col <= col + 1'b1;
              end
            end
            PH_DIV: begin
              rem     <= rem_nxt;
              quot    <= quot_nxt;
              div_cnt <= div_cnt + 1'b1;
              if (div_cnt == 5'd27) phase <= PH_NORM;
            end
            PH_NORM: begin
              q_arr[row][col] <= grad_q14(e_buf[col], r_eff, hit);
              if (col == COL_W'(CHAR_NUM-1)) begin
                col <= '0;
                if (row == ROW_W'(N-1)) begin
                  phase <= PH_FIN;
                end else begin
                  row   <= row + 1'b1;
                  phase <= PH_EXP;
                end
              end else begin
                col <= col + 1'b1;
              end
            end
            default: begin
              valid <= 1'b1;
              state <= DONE;
            end
          endcase
        end
        default: begin
          if (load_d_num) lbl <= d_num;
          if (!run) begin
            state <= IDLE;
            valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_layer_core.sv
// Scoreboard bench for softmax_layer_core: an integer model queues expected
// gradients at stimulus time; they are popped and compared once valid rises.
module tb_softmax_layer_core;
  localparam int N        = 10;
  localparam int CHAR_NUM = 200;
  localparam int CHAR_LEN = 8;
  localparam int N_LEN    = 16;
  localparam int N_LEN_W  = 16;
  localparam int LAT      = N*(2*CHAR_NUM+28)+1;

  logic clk = 1'b0;
  logic rst_n, run, load_d_num;
  logic [N*CHAR_NUM*N_LEN-1:0]   d;
  logic [N*CHAR_LEN-1:0]         d_num;
  logic [N*N_LEN-1:0]            d_max;
  logic                          valid;
  logic [N*CHAR_NUM*N_LEN_W-1:0] q;

  int checks = 0;
  int errors = 0;
  int d_arr [N][CHAR_NUM];
  int dmax_arr [N];
  int lbl_arr [N];
  logic [N_LEN_W-1:0] exp_arr [N][CHAR_NUM];
  logic [N_LEN_W-1:0] sb [$];

  softmax_layer_core dut (
    .clk(clk), .rst_n(rst_n), .run(run), .load_d_num(load_d_num),
    .d(d), .d_num(d_num), .d_max(d_max), .valid(valid), .q(q)
  );

  always #5 clk = ~clk;

  function automatic logic [N_LEN_W-1:0] q_at(int i, int j);
    return q[(i*CHAR_NUM+j)*N_LEN_W +: N_LEN_W];
  endfunction

  task automatic pack_inputs();
    for (int i = 0; i < N; i++) begin
      d_max[i*N_LEN +: N_LEN] = N_LEN'(dmax_arr[i]);
      for (int j = 0; j < CHAR_NUM; j++)
        d[(i*CHAR_NUM+j)*N_LEN +: N_LEN] = N_LEN'(d_arr[i][j]);
    end
  endtask

  task automatic random_rows();
    for (int i = 0; i < N; i++) begin
      dmax_arr[i] = -32768;
      for (int j = 0; j < CHAR_NUM; j++) begin
        d_arr[i][j] = int'($urandom_range(0, 4095)) - 2048;
        if (d_arr[i][j] > dmax_arr[i]) dmax_arr[i] = d_arr[i][j];
      end
    end
    pack_inputs();
  endtask

  task automatic load_labels();
    @(negedge clk);
    for (int i = 0; i < N; i++) d_num[i*CHAR_LEN +: CHAR_LEN] = CHAR_LEN'(lbl_arr[i]);
    load_d_num = 1'b1;
    @(negedge clk);
    load_d_num = 1'b0;
  endtask

  task automatic build_expected();
    longint x, p, y, k, f, e, s, r, qv;
    longint ev [CHAR_NUM];
    for (int i = 0; i < N; i++) begin
      s = 0;
      for (int j = 0; j < CHAR_NUM; j++) begin
        x = longint'(d_arr[i][j]) - longint'(dmax_arr[i]);
        if (x > 0) x = 0;
        p = x * 369;
        y = (p >= 0) ? p / 256 : -((-p + 255) / 256);
        k = (y >= 0) ? y / 256 : -((-y + 255) / 256);
        f = y - k * 256;
        if (-k >= 15) e = 0;
        else          e = ((256 + f) * 64) >> (-k);
        ev[j] = e;
        s += e;
      end
      r = (s == 0) ? 0 : (longint'(1) << 28) / s;
      for (int j = 0; j < CHAR_NUM; j++) begin
        qv = ((ev[j] * r) >> 14) - ((j == lbl_arr[i]) ? 16384 : 0);
        exp_arr[i][j] = qv[N_LEN_W-1:0];
        sb.push_back(qv[N_LEN_W-1:0]);
      end
    end
  endtask

  task automatic start_pass();
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int cyc, output bit to);
    cyc = 0;
    to  = 1'b0;
    while (1) begin
      @(posedge clk);
      cyc++;
      #1;
      if (valid) break;
      if (cyc >= 6000) begin
        to = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    run = 1'b0;
    load_d_num = 1'b0;
    random_rows();
    for (int i = 0; i < N; i++) d_num[i*CHAR_LEN +: CHAR_LEN] = CHAR_LEN'($urandom);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
    checks++;
    if (q !== '0) begin errors++; $display("FAIL reset_q got nonzero exp 0"); end
    @(negedge clk);
    rst_n = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", valid); end
    checks++;
    if (q !== '0) begin errors++; $display("FAIL idle_q got nonzero exp 0"); end
  endtask

  task automatic test_uniform();
    int cyc;
    bit to;
    for (int i = 0; i < N; i++) begin
      dmax_arr[i] = 0;
      lbl_arr[i]  = 5;
      for (int j = 0; j < CHAR_NUM; j++) d_arr[i][j] = 0;
    end
    pack_inputs();
    load_labels();
    build_expected();
    start_pass();
    wait_valid(cyc, to);
    checks++;
    if (to) begin errors++; $display("FAIL uniform_timeout got no valid exp valid"); end
    checks++;
    if (cyc != LAT) begin errors++; $display("FAIL uniform_latency got %0d exp %0d", cyc, LAT); end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < CHAR_NUM; j++) begin
        logic [N_LEN_W-1:0] ev;
        ev = sb.pop_front();
        checks++;
        if (q_at(i, j) !== ev) begin
          errors++;
          $display("FAIL uniform_q[%0d][%0d] got %0d exp %0d", i, j, $signed(q_at(i, j)), $signed(ev));
        end
      end
    checks++;
    if ($signed(q_at(3, 5)) !== -16'sd16303) begin
      errors++; $display("FAIL uniform_label got %0d exp -16303", $signed(q_at(3, 5)));
    end
    checks++;
    if (q_at(7, 100) !== 16'd81) begin
      errors++; $display("FAIL uniform_other got %0d exp 81", $signed(q_at(7, 100)));
    end
  endtask

  task automatic test_dominant();
    int cyc;
    bit to;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < N; i++) begin
        dmax_arr[i] = 0;
        lbl_arr[i]  = (pass == 0) ? 7 : 3;
        for (int j = 0; j < CHAR_NUM; j++) d_arr[i][j] = (j == 7) ? 0 : -4096;
      end
      pack_inputs();
      load_labels();
      build_expected();
      start_pass();
      wait_valid(cyc, to);
      checks++;
      if (to) begin errors++; $display("FAIL dominant_timeout pass %0d got no valid exp valid", pass); end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < CHAR_NUM; j++) begin
          logic [N_LEN_W-1:0] ev;
          ev = sb.pop_front();
          checks++;
          if (q_at(i, j) !== ev) begin
            errors++;
            $display("FAIL dominant%0d_q[%0d][%0d] got %0d exp %0d", pass, i, j, $signed(q_at(i, j)), $signed(ev));
          end
        end
      if (pass == 0) begin
        checks++;
        if (q_at(2, 7) !== 16'd0) begin errors++; $display("FAIL dominant_hit got %0d exp 0", $signed(q_at(2, 7))); end
      end else begin
        checks++;
        if (q_at(4, 7) !== 16'd16384) begin errors++; $display("FAIL dominant_max got %0d exp 16384", $signed(q_at(4, 7))); end
        checks++;
        if ($signed(q_at(4, 3)) !== -16'sd16384) begin errors++; $display("FAIL dominant_lbl got %0d exp -16384", $signed(q_at(4, 3))); end
      end
    end
  endtask

  task automatic test_label_staging();
    int cyc;
    bit to;
    random_rows();
    for (int i = 0; i < N; i++) lbl_arr[i] = int'($urandom_range(0, CHAR_NUM-1));
    lbl_arr[0] = 250;
    lbl_arr[1] = 200;
    load_labels();
    @(negedge clk);
    for (int i = 0; i < N; i++) d_num[i*CHAR_LEN +: CHAR_LEN] = CHAR_LEN'((lbl_arr[i] + 17) % 256);
    build_expected();
    start_pass();
    repeat (300) @(negedge clk);
    for (int i = 0; i < N; i++) d_num[i*CHAR_LEN +: CHAR_LEN] = CHAR_LEN'((lbl_arr[i] + 33) % 256);
    load_d_num = 1'b1;
    @(negedge clk);
    load_d_num = 1'b0;
    wait_valid(cyc, to);
    checks++;
    if (to) begin errors++; $display("FAIL staging_timeout got no valid exp valid"); end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < CHAR_NUM; j++) begin
        logic [N_LEN_W-1:0] ev;
        ev = sb.pop_front();
        checks++;
        if (q_at(i, j) !== ev) begin
          errors++;
          $display("FAIL staging_q[%0d][%0d] got %0d exp %0d", i, j, $signed(q_at(i, j)), $signed(ev));
        end
      end
  endtask

  task automatic test_handshake();
    int cyc;
    bit to;
    int bad;
    random_rows();
    for (int i = 0; i < N; i++) lbl_arr[i] = int'($urandom_range(0, CHAR_NUM-1));
    load_labels();
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b1) begin errors++; $display("FAIL hold_valid got %b exp 1", valid); end
    bad = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < CHAR_NUM; j++) if (q_at(i, j) !== exp_arr[i][j]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL hold_q got %0d changed elements exp 0", bad); end
    @(negedge clk);
    run = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL drop_valid got %b exp 0", valid); end
    bad = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < CHAR_NUM; j++) if (q_at(i, j) !== exp_arr[i][j]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL drop_q got %0d changed elements exp 0", bad); end
    build_expected();
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    #1;
    wait_valid(cyc, to);
    checks++;
    if (cyc != LAT) begin errors++; $display("FAIL second_latency got %0d exp %0d", cyc, LAT); end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < CHAR_NUM; j++) begin
        logic [N_LEN_W-1:0] ev;
        ev = sb.pop_front();
        checks++;
        if (q_at(i, j) !== ev) begin
          errors++;
          $display("FAIL second_q[%0d][%0d] got %0d exp %0d", i, j, $signed(q_at(i, j)), $signed(ev));
        end
      end
  endtask

  task automatic test_abort();
    int cyc;
    bit to;
    random_rows();
    start_pass();
    repeat (210) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b exp 0", valid); end
    checks++;
    if (q !== '0) begin errors++; $display("FAIL abort_q got nonzero exp 0"); end
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) lbl_arr[i] = 0;
    build_expected();
    start_pass();
    wait_valid(cyc, to);
    checks++;
    if (cyc != LAT) begin errors++; $display("FAIL abort_latency got %0d exp %0d", cyc, LAT); end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < CHAR_NUM; j++) begin
        logic [N_LEN_W-1:0] ev;
        ev = sb.pop_front();
        checks++;
        if (q_at(i, j) !== ev) begin
          errors++;
          $display("FAIL abort_rerun_q[%0d][%0d] got %0d exp %0d", i, j, $signed(q_at(i, j)), $signed(ev));
        end
      end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_dominant();
    test_label_staging();
    test_handshake();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/softmax_layer_core.md
# softmax_layer_core

Output stage of the training datapath. For each of `N` character positions it turns a row of `CHAR_NUM` fixed-point logits into softmax probabilities and subtracts the one-hot target label. The result is the cross-entropy gradient that feeds the backward pass. Target labels are captured into an internal register ahead of the run, so the next batch's labels can be presented on `d_num` while the current batch is processed.

## Interface
Parameters:
- `N`, 10, character positions (rows) per sample
- `CHAR_NUM`, 200, classes per row
- `CHAR_LEN`, 8, label index width
- `N_LEN`, 16, logit width: signed Q8.8 (`N_FRAC`=8)
- `N_LEN_W`, 16, gradient width: signed Q2.14 (`W_FRAC`=14)

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-high reset (asserted when 1)
- `run` in 1: level request; starts a pass from IDLE
- `load_d_num` in 1: capture `d_num` into the label register
- `d` in `N*CHAR_NUM*N_LEN`: logits; element (i,j) at `d[(i*CHAR_NUM+j)*N_LEN +: N_LEN]`
- `d_num` in `N*CHAR_LEN`: label of row i at `[i*CHAR_LEN +: CHAR_LEN]`
- `d_max` in `N*N_LEN`: row maximum of row i at `[i*N_LEN +: N_LEN]`
- `valid` out 1: result ready
- `q` out `N*CHAR_NUM*N_LEN_W`: gradient (i,j) at `[(i*CHAR_NUM+j)*N_LEN_W +: N_LEN_W]`

## Operation
- Label register `lbl` loads `d_num` on any clock edge with `load_d_num`=1 while in IDLE or DONE. `load_d_num` is ignored while BUSY.
- Per element:
  - x = d_ij − d_max_i, signed 17 bit. Values of x > 0 are clamped to 0.
  - y = (x·369) >>> 8, arithmetic shift with floor; 369 is log2(e) in Q8.
  - k = y >>> 8 and f = y[7:0].
  - e_ij = ((256+f) << 6) >> (−k). If −k ≥ 15, e_ij = 0. Range 0..16384, Q1.14.
- Per row:
  - S_i = Σ_j e_ij, unsigned, `16+ceil(log2 CHAR_NUM)` bits.
  - r_i = floor(2^28 / S_i), computed by a bit-serial restoring divider.
  - S_i = 0 (possible only if d_max is not a true maximum) forces r_i = 0.
- Output: q_ij = ((e_ij·r_i) >> 14) − (j==lbl_i ? 16384 : 0), signed `N_LEN_W`.
  - Labels ≥ `CHAR_NUM` subtract nothing.
- FSM:
  - IDLE → BUSY on `run`=1.
  - BUSY runs three phases for each row i = 0..N−1:
    - EXP: one element per cycle, e stored in a `CHAR_NUM`-entry buffer, sum accumulated.
    - DIV: 28 iterations.
    - NORM: one q element per cycle.
  - BUSY → DONE after the last row; `valid` is set.
  - DONE → IDLE when `run`=0.
- `d`, `d_max` and `lbl` must stay stable from start until `valid`. `d_num` may change freely.

## Timing
- Reset values: `valid`=0, `q`=0, `lbl`=0, e buffer and sums 0, state IDLE.
- Reset asserted mid-pass aborts immediately with the same values.
- Start: the first edge with `run`=1 in IDLE samples the pass.
- Latency: exactly L = N·(2·CHAR_NUM+28)+1 cycles from the start edge to the edge setting `valid`.
  - L is data-independent.
  - For the default parameters L = 4281.
- `valid` stays 1 and `q` stays constant while `run`=1; no restart occurs while `run` remains high.
- `valid` falls on the first edge with `run`=0.
- `q` holds its last value until the next pass overwrites it element by element.
- Re-asserting `run` on the cycle after it drops starts a new pass.

## Test plan
- Reset: assert `rst_n`=1 with random inputs -> `valid`=0, `q`=0. Release, then hold `run`=0 for 100 cycles -> no change.
- Uniform row: all d=0, d_max=0, lbl_i=5 -> e=16384, r=81, so q_i,5 = 81−16384 = −16303 and every other q_i,j = 81. `valid` occurs exactly 4281 cycles after start.
- Dominant logit: in each row d_i,7=0 and all others −16.0 (−4096), d_max=0, lbl_i=7 -> all q=0. With lbl_i=3 instead -> q_i,7 = 16384, q_i,3 = −16384, others 0.
- Label staging: load labels A with `load_d_num`, change `d_num` to B, then run -> the result uses A. Pulse `load_d_num` while BUSY -> ignored.
- Handshake: hold `run` 1 cycle past `valid` -> `q` stable with no new pass. Drop `run` -> `valid`=0 on the next edge. A second pass with new d/labels -> new correct `q`.
- Abort: assert reset midway through the DIV phase -> `valid`=0, `q`=0. A fresh run afterwards gives the correct result.
